// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite write slave.
// Contents: BRESP encodings and the write-path FSM state type.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HAVE_ADDR = 2'd1,
    HAVE_DATA = 2'd2,
    RESP      = 2'd3
  } state_e;

endpackage

// File: rtl/wstrb_merge.sv
// Byte-lane merge of a 32-bit write into an existing word.
// Ports:
//   old_i    - current register contents
//   new_i    - incoming write data
//   strb_i   - byte strobes, bit i selects new_i[8i+7:8i]
//   merged_o - resulting word
module wstrb_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  strb_i,
  output logic [31:0] merged_o
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged_o[8*i +: 8] = strb_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
  end

endmodule

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write-path responder with a bank of NUM_REGS 32-bit registers.
// AW and W may arrive in either order or together; one transaction at a time.
// Ports:
//   ACLK, ARESETn           - clock, async active-low reset
//   AWADDR/AWVALID/AWREADY  - write address channel
//   WDATA/WSTRB/WVALID/WREADY - write data channel
//   BRESP/BVALID/BREADY     - write response channel
//   reg_q                   - register bank, register k at [32k+31:32k]
//   wr_pulse                - one-cycle pulse on the register written
// Build option: AXI_LITE_WSLV_DECERR_EN makes out-of-range writes answer
// DECERR; otherwise they answer OKAY and are dropped.
//
// state     | meaning
// ----------+---------------------------------------------
// IDLE      | waiting for AW and/or W
// HAVE_ADDR | address latched, waiting for W
// HAVE_DATA | data/strobe latched, waiting for AW
// RESP      | write committed, BVALID high until BREADY
module axi_lite_write_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [ADDR_WIDTH-1:0]    AWADDR,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int IDXW = $clog2(NUM_REGS);

`ifdef AXI_LITE_WSLV_DECERR_EN
  localparam logic [1:0] OOR_RESP = RESP_DECERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  state_e                  state_q, state_d;
  logic                    awready_q, wready_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             data_q;
  logic [3:0]              strb_q;
  logic [NUM_REGS*32-1:0]  regs_q;
  logic [NUM_REGS-1:0]     wr_pulse_q;
  logic [1:0]              bresp_q;

  logic                    aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [31:0]             c_data, merged;
  logic [3:0]              c_strb;
  logic [IDXW-1:0]         idx;
  logic                    in_range;

  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Commit operands come from the live bus or from whichever half was latched.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    c_addr  = AWADDR;
    c_data  = WDATA;
    c_strb  = WSTRB;
    case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          state_d = RESP;
        end else if (aw_hs) begin
          state_d = HAVE_ADDR;
        end else if (w_hs) begin
          state_d = HAVE_DATA;
        end
      end
      HAVE_ADDR: begin
        c_addr = addr_q;
        if (w_hs) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      HAVE_DATA: begin
        c_data = data_q;
        c_strb = strb_q;
        if (aw_hs) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx      = c_addr[2 +: IDXW];
  assign in_range = (c_addr >> (2 + IDXW)) == '0;

  wstrb_merge u_merge (
    .old_i    (regs_q[32*int'(idx) +: 32]),
    .new_i    (c_data),
    .strb_i   (c_strb),
    .merged_o (merged)
  );

  // Readies are registered from the next state so they stay low in reset
  // and come up on the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      awready_q  <= (state_d == IDLE) || (state_d == HAVE_DATA);
      wready_q   <= (state_d == IDLE) || (state_d == HAVE_ADDR);
      wr_pulse_q <= '0;
      if (state_q == IDLE && aw_hs && !w_hs) addr_q <= AWADDR;
      if (state_q == IDLE && w_hs && !aw_hs) begin
        data_q <= WDATA;
        strb_q <= WSTRB;
      end
      if (commit) begin
        if (in_range) begin
          regs_q[32*int'(idx) +: 32] <= merged;
          wr_pulse_q                 <= NUM_REGS'(1) << idx;
          bresp_q                    <= RESP_OKAY;
        end else begin
          bresp_q <= OOR_RESP;
        end
      end
    end
  end

  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BVALID   = (state_q == RESP);
  assign BRESP    = bresp_q;
  assign reg_q    = regs_q;
  assign wr_pulse = wr_pulse_q;

endmodule
